alu_unit: RTL and testbench



---
 rtl/alu_unit_if.sv | 22 ++
 rtl/alu_unit.sv | 63 ++++++
 tb/tb_alu_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_unit_if.sv
// Operand/result bundle between the pico_mips datapath and its ALU.
// The datapath drives the operation select and operands. The ALU returns the live result and the registered copies.
interface alu_unit_if;
    logic       alu_ctrl;
    logic [7:0] input1;
    logic [7:0] input2;
    logic [7:0] result;
    logic [7:0] result_q;
    logic       flag_z;
    logic       flag_n;
    logic       flag_v;

    modport master (
        output alu_ctrl, input1, input2,
        input  result, result_q, flag_z, flag_n, flag_v
    );

    modport slave (
        input  alu_ctrl, input1, input2,
        output result, result_q, flag_z, flag_n, flag_v
    );
endinterface

// File: rtl/alu_unit.sv
// 8-bit signed ALU: wrapping add or Q1.7 fractional multiply, with a combinational result
// plus a registered result and Z/N/V flags for the following instruction.
module alu_unit (
    input  logic       clk,
    input  logic       rst,
    alu_unit_if.slave  bus
);

    logic signed [7:0]  opA;
    logic signed [7:0]  opB;
    logic        [7:0]  sum;
    logic signed [15:0] product;
    logic        [7:0]  result_d;
    logic               zero_d;
    logic               neg_d;
    logic               ovf_d;

    logic [7:0] result_q;
    logic       zero_q;
    logic       neg_q;
    logic       ovf_q;

    assign opA     = $signed(bus.input1);
    assign opB     = $signed(bus.input2);
    assign sum     = bus.input1 + bus.input2;
    assign product = 16'(opA) * 16'(opB);

    // Multiply keeps P[14:7] (floor of the Q1.7 product); V flags the lone -1 * -1 case where P[15] != P[14].
    always_comb begin
        result_d = sum;
        ovf_d    = 1'b0;
        if (bus.alu_ctrl) begin
            result_d = sum;
            ovf_d    = (bus.input1[7] == bus.input2[7]) && (sum[7] != bus.input1[7]);
        end else begin
            result_d = product[14:7];
            ovf_d    = product[15] ^ product[14];
        end
        zero_d = (result_d == 8'h00);
        neg_d  = result_d[7];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 8'h00;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.result   = result_d;
    assign bus.result_q = result_q;
    assign bus.flag_z   = zero_q;
    assign bus.flag_n   = neg_q;
    assign bus.flag_v   = ovf_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit. The directed corner cases come first, then 1000 random operand pairs per mode.
// The random results are compared against an integer-arithmetic reference model.
module tb_alu_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_unit_if bus ();

    alu_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Reference model in plain signed integer arithmetic: V means the true value left the representable range.
    function automatic void model(input bit ctrl, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic z, output logic n,
                                  output logic v);
        int sa;
        int sb;
        int full;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (ctrl) full = sa + sb;
        else      full = (sa * sb) >>> 7;
        r = 8'(full & 255);
        v = (full > 127) || (full < -128);
        z = (r == 8'h00);
        n = (r >= 8'd128);
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input bit ctrl, input logic [7:0] a,
                                 input logic [7:0] b, input bit rstVal, input logic [7:0] expR,
                                 input logic expZ, input logic expN, input logic expV);
        @(negedge clk);
        bus.alu_ctrl = ctrl;
        bus.input1   = a;
        bus.input2   = b;
        rst          = rstVal;
        #40;
        checkOutput({tag, ".result"}, bus.result, expR);
        @(posedge clk);
        #1;
        if (rstVal) begin
            checkOutput({tag, ".result_q"}, bus.result_q, 8'h00);
            checkOutput({tag, ".flags"}, {5'd0, bus.flag_z, bus.flag_n, bus.flag_v}, 8'h00);
        end else begin
            checkOutput({tag, ".result_q"}, bus.result_q, expR);
            checkOutput({tag, ".flags"}, {5'd0, bus.flag_z, bus.flag_n, bus.flag_v},
                        {5'd0, expZ, expN, expV});
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       z;
        logic       n;
        logic       v;

        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus.alu_ctrl = 1'b1;
        bus.input1   = 8'h00;
        bus.input2   = 8'h00;

        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset.result_q", bus.result_q, 8'h00);
        checkOutput("reset.flags", {5'd0, bus.flag_z, bus.flag_n, bus.flag_v}, 8'h00);

        applyStimulus("add_basic", 1'b1, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
        applyStimulus("add_ovf",   1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        applyStimulus("add_wrap",  1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus("add_negov", 1'b1, 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        applyStimulus("mul_half",  1'b0, 8'h40, 8'h40, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0);
        applyStimulus("mul_neg",   1'b0, 8'hC0, 8'h40, 1'b0, 8'hE0, 1'b0, 1'b1, 1'b0);
        applyStimulus("mul_trunc", 1'b0, 8'h01, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus("mul_floor", 1'b0, 8'hFF, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);
        applyStimulus("mul_m1m1",  1'b0, 8'h80, 8'h80, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        applyStimulus("mul_max",   1'b0, 8'h7F, 8'h7F, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0);
        applyStimulus("mid_reset", 1'b1, 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1);
        applyStimulus("resume",    1'b1, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);

        for (int mode = 0; mode < 2; mode++) begin
            for (int i = 0; i < 1000; i++) begin
                a = 8'($urandom);
                b = 8'($urandom);
                model(mode[0], a, b, r, z, n, v);
                applyStimulus($sformatf("rand_%s_%0d", mode[0] ? "add" : "mul", i),
                              mode[0], a, b, 1'b0, r, z, n, v);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
